// File: rtl/seg_ascii_pkg.sv
// rtl/seg_ascii_pkg.sv - segment patterns, qualifier states and pattern-to-ASCII lookup
package seg_ascii_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } qual_state_t;

    localparam logic [6:0] CHAR_UNKNOWN = 7'h3F;

    // Segment order {g,f,e,d,c,b,a}, a = bit 0, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_G     = 7'h3D;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_J     = 7'h1E;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_N     = 7'h37;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_Q     = 7'h67;
    localparam logic [6:0] SEG_R     = 7'h31;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_Y     = 7'h6E;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_UNDER = 7'h08;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Returns {unknown, char}; patterns shared between glyphs resolve to digits
    function automatic logic [7:0] seg_to_ascii(input logic [6:0] pattern);
        logic [7:0] res;
        res = {1'b1, CHAR_UNKNOWN};
        case (pattern)
            SEG_0:     res = 8'h30;
            SEG_1:     res = 8'h31;
            SEG_2:     res = 8'h32;
            SEG_3:     res = 8'h33;
            SEG_4:     res = 8'h34;
            SEG_5:     res = 8'h35;
            SEG_6:     res = 8'h36;
            SEG_7:     res = 8'h37;
            SEG_7_ALT: res = 8'h37;
            SEG_8:     res = 8'h38;
            SEG_9:     res = 8'h39;
            SEG_A:     res = 8'h41;
            SEG_B:     res = 8'h42;
            SEG_C:     res = 8'h43;
            SEG_D:     res = 8'h44;
            SEG_E:     res = 8'h45;
            SEG_F:     res = 8'h46;
            SEG_G:     res = 8'h47;
            SEG_H:     res = 8'h48;
            SEG_J:     res = 8'h4A;
            SEG_L:     res = 8'h4C;
            SEG_N:     res = 8'h4E;
            SEG_P:     res = 8'h50;
            SEG_Q:     res = 8'h51;
            SEG_R:     res = 8'h52;
            SEG_U:     res = 8'h55;
            SEG_Y:     res = 8'h59;
            SEG_DASH:  res = 8'h2D;
            SEG_UNDER: res = 8'h5F;
            SEG_BLANK: res = 8'h20;
            default:   res = {1'b1, CHAR_UNKNOWN};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_char_fifo.sv
// rtl/seg_char_fifo.sv - small synchronous FIFO for decoded character entries
module seg_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop on a full queue frees the slot the coincident push needs
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seg_ascii_reader.sv
// rtl/seg_ascii_reader.sv - qualifies a 7-segment bus, decodes to ASCII and queues characters
module seg_ascii_reader
    import seg_ascii_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] seg_in,
    input  logic       al,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_char,
    output logic       out_unknown,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    qual_state_t      state;
    logic [6:0]       pat_q;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       last_pat;
    logic             last_vld;

    logic [6:0]       norm;
    logic             attempt;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             drop;
    logic [7:0]       entry;
    logic [7:0]       head;

    assign norm    = al ? seg_in : ~seg_in;
    // Final settle cycle: the pattern has now been seen unchanged long enough
    assign attempt = en && (norm == pat_q) && (state == SETTLE) && (cnt == CNT_LAST);
    // The same pattern twice in a row is one character, not two
    assign push    = attempt && (!last_vld || (pat_q != last_pat));
    assign push_ok = push && (!fifo_full || out_ready);
    assign drop    = push && fifo_full && !out_ready;
    assign entry   = seg_to_ascii(pat_q);

    seg_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (entry),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_char    = fifo_empty ? 7'h00 : head[6:0];
    assign out_unknown = fifo_empty ? 1'b0  : head[7];

    // Stability qualifier, dedup memory and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SETTLE;
            pat_q    <= '0;
            cnt      <= '0;
            last_pat <= '0;
            last_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (!en) begin
                cnt   <= '0;
                state <= SETTLE;
            end else if (norm != pat_q) begin
                pat_q <= norm;
                cnt   <= '0;
                state <= SETTLE;
            end else if (state == SETTLE) begin
                if (cnt == CNT_LAST) begin
                    state <= LOCKED;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (push_ok) begin
                last_pat <= pat_q;
                last_vld <= 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_ascii_reader.sv
// tb/tb_seg_ascii_reader.sv - scoreboard bench for seg_ascii_reader
module tb_seg_ascii_reader;

    localparam int STABLE = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       al = 1'b1;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_char;
    logic       out_unknown;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    seg_ascii_reader #(
        .STABLE_CYCLES (STABLE),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .seg_in      (seg_in),
        .al          (al),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .out_unknown (out_unknown),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    // Reference glyph table: pattern i displays character tbl_chr[i]
    logic [6:0] tbl_pat [30] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h27, 7'h7F,
                                 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h1E,
                                 7'h38, 7'h37, 7'h73, 7'h67, 7'h31, 7'h3E, 7'h6E, 7'h40, 7'h08, 7'h00};
    string tbl_chr = "01234567789ABCDEFGHJLNPQRUY-_ ";

    function automatic logic [7:0] ref_lookup(input logic [6:0] p);
        for (int i = 0; i < 30; i++) begin
            if (tbl_pat[i] == p) return {1'b0, 7'(tbl_chr[i])};
        end
        return {1'b1, 7'h3F};
    endfunction

    // Behavioural model: run length of the current pattern, expected output queue
    logic [6:0] m_pat = 7'h00;
    int         m_age = 0;
    logic [6:0] m_last_pat = 7'h00;
    bit         m_last_vld = 0;
    bit         m_ovf = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        logic [6:0] n;
        bit attempt;
        bit pop;
        bit dropped;
        if (rst) begin
            m_pat = 7'h00; m_age = 0; m_last_pat = 7'h00; m_last_vld = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            n = al ? seg_in : ~seg_in;
            attempt = 0;
            dropped = 0;
            if (!en) begin
                m_age = 0;
            end else if (n != m_pat) begin
                m_pat = n;
                m_age = 0;
            end else begin
                if (m_age <= STABLE) m_age++;
                if (m_age == STABLE) attempt = 1;
            end
            pop = (exp_q.size() > 0) && out_ready;
            if (attempt && (!m_last_vld || m_pat != m_last_pat)) begin
                if (exp_q.size() < DEPTH || pop) begin
                    if (pop) begin
                        void'(exp_q.pop_front());
                        pop = 0;
                    end
                    exp_q.push_back(ref_lookup(m_pat));
                    m_last_pat = m_pat;
                    m_last_vld = 1;
                end else begin
                    dropped = 1;
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (dropped) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compare DUT presentation against the scoreboard every cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", int'(out_valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("char", int'(out_char), int'(exp_q[0][6:0]));
                chk("unknown", int'(out_unknown), int'(exp_q[0][7]));
            end else begin
                chk("empty_char", int'(out_char), 0);
                chk("empty_unknown", int'(out_unknown), 0);
            end
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = al ? p : ~p;
        step(n);
    endtask

    initial begin
        // 1: '3' appears exactly on the fifth edge after the change
        rst = 1; al = 1; en = 1; seg_in = 7'h4F; out_ready = 1;
        step(2);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_char", int'(out_char), 0);
        chk("reset_ovf", int'(overflow), 0);
        rst = 0;
        step(4);
        chk("lat_edge4", int'(out_valid), 0);
        step(1);
        chk("lat_edge5", int'(out_valid), 1);
        chk("lat_char", int'(out_char), 8'h33);
        chk("lat_unknown", int'(out_unknown), 0);
        step(6);
        chk("no_repeat", int'(out_valid), 0);

        // 2: short glitch never queued
        hold(7'h06, 2);
        hold(7'h5B, 5);
        chk("glitch_char", int'(out_char), 8'h32);
        step(2);

        // 3: active-low, blank separates repeats; en gap alone does not
        al = 0;
        hold(7'h77, 6);
        hold(7'h00, 6);
        hold(7'h77, 6);
        en = 0; step(2); en = 1;
        hold(7'h77, 6);

        // 4: unmapped pattern
        al = 1;
        hold(7'h49, 5);
        chk("unk_char", int'(out_char), 8'h3F);
        chk("unk_flag", int'(out_unknown), 1);
        step(2);

        // 5: overflow on a full queue, then drain and clear
        out_ready = 0;
        hold(7'h3F, 6);
        hold(7'h06, 6);
        hold(7'h5B, 6);
        hold(7'h4F, 6);
        hold(7'h66, 6);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head", int'(out_char), 8'h30);
        out_ready = 1;
        step(6);
        clr_ovf = 1; step(1); clr_ovf = 0;
        chk("ovf_clr", int'(overflow), 0);

        // 6: push coincident with pop on a full queue, then reset mid-stream
        out_ready = 0;
        hold(7'h6D, 6);
        hold(7'h7D, 6);
        hold(7'h07, 6);
        hold(7'h7F, 6);
        seg_in = 7'h6F;
        step(4);
        out_ready = 1;
        step(1);
        out_ready = 0;
        chk("full_pp_ovf", int'(overflow), 0);
        chk("full_pp_head", int'(out_char), 8'h36);
        step(1);
        rst = 1;
        step(1);
        chk("rst_mid_valid", int'(out_valid), 0);
        rst = 0;

        // Randomized traffic
        for (int s = 0; s < 300; s++) begin
            logic [6:0] p;
            int len;
            if ($urandom_range(0, 9) < 8) p = tbl_pat[$urandom_range(0, 29)];
            else p = 7'($urandom);
            if ($urandom_range(0, 9) == 0) al = ~al;
            en = ($urandom_range(0, 9) != 0);
            seg_in = al ? p : ~p;
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                clr_ovf = ($urandom_range(0, 15) == 0);
                step(1);
            end
        end
        clr_ovf = 0;
        out_ready = 1;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
